// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one SRAM-like req/addr_ok/data_ok port between the instruction
//   fetch requester (inst_*) and the load/store requester (data_*).
//   Accepted transactions are tracked in issue order by an owner FIFO so
//   that each mem_data_ok / mem_rdata is steered back to its issuer.
//
// Ports
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   inst_req/wr/size/wstrb/addr/wdata   inst request side (inputs)
//   inst_addr_ok/data_ok/rdata          inst response side (outputs)
//   data_*                              same set for the data requester
//   mem_req/wr/size/wstrb/addr/wdata    shared request to the bridge (outputs)
//   mem_addr_ok/data_ok/rdata           shared response from the bridge (inputs)
//
// Parameters
//   MAX_OUTSTANDING  accepted-but-unanswered transactions allowed (1..16, power of 2)
//
// Configuration macro
//   SRAM_ARB_RR_EN   defined: round-robin between requesters (last_grant flop)
//                    undefined: fixed data-over-inst priority
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           count, count_nxt;
  logic [MAX_OUTSTANDING-1:0] owner_q;   // 0 = inst, 1 = data
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic                       hs, pop, head, room;
  logic                       inst_pend, data_pend, pick_data;
  mreq_t                      inst_r, data_r, sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign hs   = mem_req & mem_addr_ok;
  // A response with nothing outstanding (spurious or left over from before
  // a reset) is dropped here so it never reaches a requester.
  assign pop  = mem_data_ok & (count != '0);
  assign head = owner_q[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({hs, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Grant decisions look at the post-update occupancy, so a GNT state can
  // never be entered with the FIFO full, and a pop frees a slot at once.
  assign room = (count_nxt < CNT_W'(MAX_OUTSTANDING));

  // The requester being accepted this cycle is already served; masking it
  // keeps a req still high during its own addr_ok cycle from being granted
  // a second, phantom transaction.
  assign inst_pend = inst_req & ~inst_addr_ok;
  assign data_pend = data_req & ~data_addr_ok;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;  // 1 = data was granted last

  always_ff @(posedge clk) begin
    if (reset)   last_grant <= 1'b1;
    else if (hs) last_grant <= (state == GNT_D);
  end

  assign pick_data = data_pend & (~inst_pend | ~last_grant);
`else
  assign pick_data = data_pend;
`endif

  always_comb begin
    state_nxt = state;
    if (state == IDLE || hs) begin
      if ((inst_pend | data_pend) & room)
        state_nxt = pick_data ? GNT_D : GNT_I;
      else
        state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      owner_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (hs) begin
        owner_q[wr_ptr] <= (state == GNT_D);
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  assign inst_r = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                    addr: inst_addr, wdata: inst_wdata};
  assign data_r = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                    addr: data_addr, wdata: data_wdata};

  always_comb begin
    sel = '0;
    case (state)
      GNT_I:   sel = inst_r;
      GNT_D:   sel = data_r;
      default: sel = '0;
    endcase
  end

  assign mem_req   = (state != IDLE);
  assign mem_wr    = sel.wr;
  assign mem_size  = sel.size;
  assign mem_wstrb = sel.wstrb;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;

  assign inst_addr_ok = mem_addr_ok & (state == GNT_I);
  assign data_addr_ok = mem_addr_ok & (state == GNT_D);

  // Zero-latency response steering; rdata is shared, data_ok qualifies it.
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter (MAX_OUTSTANDING = 4).
// Expected response owners are queued when an accept is expected and
// popped when the bench drives mem_data_ok.
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          who;    // 0 = inst, 1 = data
    logic        wr;
    logic [31:0] addr;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    step();
    step();
    reset = 0;
    exp_q.delete();
  endtask

  // who: 0 inst accepted, 1 data accepted, -1 nobody accepted
  task automatic expect_accept(input string nm, input int who);
    chk({nm, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'(who == 0));
    chk({nm, "_data_addr_ok"}, 32'(data_addr_ok), 32'(who == 1));
    if (who >= 0) exp_q.push_back(who);
  endtask

  task automatic respond(input string nm, input logic [31:0] r);
    int e;
    mem_rdata   = r;
    mem_data_ok = 1;
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk({nm, "_inst_data_ok"}, 32'(inst_data_ok), 32'(e == 0));
    chk({nm, "_data_data_ok"}, 32'(data_data_ok), 32'(e == 1));
    if (e == 0) chk({nm, "_inst_rdata"}, inst_rdata, r);
    if (e == 1) chk({nm, "_data_rdata"}, data_rdata, r);
    step();
    mem_data_ok = 0;
  endtask

  task automatic set_req(input int who, input logic v);
    if (who == 0) inst_req = v;
    else          data_req = v;
  endtask

  initial begin
    vec_t tv[4];
    int   first, acc;

    tv[0] = '{who: 0, wr: 1'b0, addr: 32'h1c00_0040, rdata: 32'h1111_0001};
    tv[1] = '{who: 1, wr: 1'b1, addr: 32'h8000_0020, rdata: 32'h2222_0002};
    tv[2] = '{who: 0, wr: 1'b0, addr: 32'h1c00_0044, rdata: 32'h3333_0003};
    tv[3] = '{who: 1, wr: 1'b0, addr: 32'h8000_0024, rdata: 32'h4444_0004};

    // reset state
    do_reset();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst_aok", 32'(inst_addr_ok), 0);
    chk("rst_data_aok", 32'(data_addr_ok), 0);
    chk("rst_inst_dok", 32'(inst_data_ok), 0);
    chk("rst_data_dok", 32'(data_data_ok), 0);
    chk("rst_count", 32'(dut.count), 0);

    // single inst read
    inst_req = 1; inst_addr = 32'h1c00_0000;
    #1;
    chk("a_latency", 32'(mem_req), 0);
    step();
    chk("a_mem_req", 32'(mem_req), 1);
    chk("a_mem_addr", mem_addr, 32'h1c00_0000);
    chk("a_mem_size", 32'(mem_size), 2);
    expect_accept("a_wait", -1);
    step();
    mem_addr_ok = 1;
    #1;
    expect_accept("a_acc", 0);
    step();
    inst_req = 0; mem_addr_ok = 0;
    #1;
    chk("a_idle", 32'(mem_req), 0);
    step();
    respond("a_resp", 32'hDEAD_BEEF);

    // simultaneous inst + data over 4 repeated pairs
    do_reset();
    data_wr = 1; data_addr = 32'h8000_0010; data_wstrb = 4'b0011;
    data_size = 2'd1; data_wdata = 32'h0000_55aa;
    inst_addr = 32'h1c00_0100;
`ifdef SRAM_ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    for (int p = 0; p < 4; p++) begin
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      step();
      expect_accept($sformatf("b%0d_first", p), first);
      if (first == 1) begin
        chk("b_mem_wr", 32'(mem_wr), 1);
        chk("b_mem_addr", mem_addr, 32'h8000_0010);
        chk("b_mem_wstrb", 32'(mem_wstrb), 32'h3);
      end
      set_req(first, 0);
      step();
      expect_accept($sformatf("b%0d_second", p), 1 - first);
      set_req(1 - first, 0);
      step();
      mem_addr_ok = 0;
      chk("b_idle", 32'(mem_req), 0);
      respond("b_resp0", 32'hB000_0000 + 32'(2 * p));
      respond("b_resp1", 32'hB000_0001 + 32'(2 * p));
    end

    // interleaved transactions from the table, responses in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (tv[i].who == 0) begin inst_addr = tv[i].addr; inst_wr = tv[i].wr; end
      else                begin data_addr = tv[i].addr; data_wr = tv[i].wr; end
      set_req(tv[i].who, 1);
      mem_addr_ok = 1;
      step();
      expect_accept($sformatf("c%0d", i), tv[i].who);
      chk($sformatf("c%0d_addr", i), mem_addr, tv[i].addr);
      chk($sformatf("c%0d_wr", i), 32'(mem_wr), 32'(tv[i].wr));
      set_req(tv[i].who, 0);
      step();
    end
    mem_addr_ok = 0;
    for (int i = 0; i < 4; i++) respond($sformatf("c%0d_resp", i), tv[i].rdata);

    // spurious response with nothing outstanding
    respond("d_spur", 32'h1234_5678);
    chk("d_count", 32'(dut.count), 0);

    // fill to MAX_OUTSTANDING with continuous inst_req
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0200; mem_addr_ok = 1;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (inst_addr_ok) acc++;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(0);
    chk("e_accepts", 32'(acc), 4);
    chk("e_full_mem_req", 32'(mem_req), 0);
    chk("e_full_count", 32'(dut.count), 4);
    respond("e_pop", 32'hE000_0001);
    chk("e_regrant", 32'(mem_req), 1);
    chk("e_count3", 32'(dut.count), 3);
    expect_accept("e_push", 0);
    respond("e_pushpop", 32'hE000_0002);
    chk("e_count_same", 32'(dut.count), 3);
    inst_req = 0; mem_addr_ok = 0;
    step();
    for (int k = 0; k < 3; k++) respond("e_drain", 32'hE000_0010 + 32'(k));
    chk("e_count0", 32'(dut.count), 0);

    // reset with 3 outstanding
    for (int i = 0; i < 3; i++) begin
      set_req(tv[i].who, 1);
      mem_addr_ok = 1;
      step();
      expect_accept($sformatf("f%0d", i), tv[i].who);
      set_req(tv[i].who, 0);
      step();
    end
    mem_addr_ok = 0;
    reset = 1;
    step();
    chk("f_mem_req", 32'(mem_req), 0);
    chk("f_count", 32'(dut.count), 0);
    reset = 0;
    exp_q.delete();
    respond("f_stale", 32'hF000_0000);
    chk("f_count_after", 32'(dut.count), 0);

    // requester drops req while granted: grant held until addr_ok
    inst_req = 1; inst_addr = 32'h1c00_0300;
    step();
    inst_req = 0;
    step();
    chk("g_held_req", 32'(mem_req), 1);
    chk("g_held_addr", mem_addr, 32'h1c00_0300);
    mem_addr_ok = 1;
    #1;
    expect_accept("g_acc", 0);
    step();
    mem_addr_ok = 0;
    chk("g_idle", 32'(mem_req), 0);
    respond("g_resp", 32'h6000_0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
